trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer between the execute stage and the CSR register file.
- Accepts synchronous exceptions (ecall, ebreak), mret, and one machine-timer interrupt.
- Uses the CSR file's single exception write port to update mepc, mcause and mstatus one per cycle, then issues a pipeline redirect to the trap vector or the return address.
- Holds the pipeline for the whole sequence.

Parameters:
- XLEN, 32, data/address width of CSR values and PCs.
- CSR_AW, 12, CSR address width.
- IRQ_CAUSE, 32'h8000_0007, mcause value written for the timer interrupt.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- inst_valid_i  input  1  execute-stage instruction valid.
- inst_addr_i  input  XLEN  PC of the execute-stage instruction.
- ecall_i  input  1  execute-stage instruction is ecall.
- ebreak_i  input  1  execute-stage instruction is ebreak.
- mret_i  input  1  execute-stage instruction is mret.
- irq_i  input  1  timer interrupt pending, level.
- mtvec_i  input  XLEN  current mtvec from the CSR file.
- mepc_i  input  XLEN  current mepc from the CSR file.
- mstatus_i  input  XLEN  current mstatus from the CSR file.
- excp_we_o  output  1  CSR exception-port write enable.
- excp_waddr_o  output  CSR_AW  CSR exception-port address.
- excp_wdata_o  output  XLEN  CSR exception-port data.
- hold_o  output  1  stall fetch/decode/execute.
- jump_o  output  1  one-cycle pipeline redirect.
- jump_addr_o  output  XLEN  redirect target.

Behaviour:
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTAT, T_JUMP, R_MSTAT, R_JUMP.
- Reset: state IDLE, all latches 0. excp_we_o, excp_waddr_o, excp_wdata_o, jump_o, jump_addr_o and hold_o are all 0. Reset in any state aborts the sequence; no further CSR writes occur.
- Accept, in IDLE only, when inst_valid_i=1.
  - Priority: ecall > ebreak > mret > irq.
  - irq is taken only if mstatus_i[3] (MIE)=1 and no synchronous event is present.
  - Events arriving in any other state are ignored; the pipeline is held, so they are not lost.
- On accept, latch epc=inst_addr_i and ms=mstatus_i. Latch cause: ecall=32'd11, ebreak=32'd3, irq=IRQ_CAUSE.
  - For irq, the interrupted instruction is not executed; epc is its PC.
- Trap path: IDLE -> W_MEPC -> W_MCAUSE -> W_MSTAT -> T_JUMP -> IDLE, one cycle each.
  - W_MEPC: we=1, addr 12'h341, data epc.
  - W_MCAUSE: we=1, addr 12'h342, data cause.
  - W_MSTAT: we=1, addr 12'h300, data is ms with bit7 (MPIE)=ms[3] and bit3 (MIE)=0; other bits unchanged.
  - T_JUMP: jump_o=1, jump_addr_o={mtvec_i[XLEN-1:2],2'b00} (direct mode only).
- mret path: IDLE -> R_MSTAT -> R_JUMP -> IDLE.
  - R_MSTAT: we=1, addr 12'h300, data is ms with bit3=ms[7] and bit7=1.
  - R_JUMP: jump_o=1, jump_addr_o=mepc_i.
- Outputs are decoded from state and latches only (Moore). When a state does not drive them, excp_we_o=0, excp_waddr_o=0, excp_wdata_o=0, jump_o=0, jump_addr_o=0.
- hold_o:
  - Combinational: 1 in the accept cycle and in every non-IDLE state, including the jump cycle.
  - 0 in IDLE with no accepted event.
- Exactly one CSR write per cycle. Write order is fixed: mepc, mcause, mstatus.
- Sequence latency from accept to jump: trap = 4 cycles, mret = 2 cycles.
- A new event may be accepted in the cycle after the jump cycle (IDLE).
- Multiple event flags together: only the highest-priority one is serviced. Lower flags are dropped; the redirect flushes their instruction.
- irq_i deasserting mid-sequence has no effect; the cause is already latched.

Test Plan:
- ecall at inst_addr_i=32'h0000_0100, mstatus_i=32'h8, mtvec_i=32'h0000_0200 -> cycles 1-3 write 0x341=0x100, 0x342=11, 0x300=0x80. Cycle 4 jump_o=1 to 0x200. hold_o=1 for cycles 0-4, then 0.
- mret with mstatus_i=32'h80, mepc_i=32'h104 -> cycle 1 writes 0x300=0x88. Cycle 2 jump_o=1 to 0x104.
- irq_i=1 with mstatus_i=0 -> no accept, hold_o=0. Set mstatus_i=8, inst_addr_i=0x40 -> mepc=0x40, mcause=0x8000_0007, mstatus=0x80.
- ecall, ebreak and irq together (MIE=1) -> mcause=11 only, a single sequence. ebreak alone -> mcause=3.
- Assert rst during W_MCAUSE -> next cycle all outputs 0, state IDLE, no mstatus write or jump afterwards.
- mtvec_i=32'h0000_0203 -> jump_addr_o=32'h0000_0200. An ecall held asserted through the sequence is not re-accepted before the post-jump IDLE cycle.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Execute-stage / CSR-file side bundle of the machine-mode trap sequencer.
// The master modport is the sequencer itself; the slave modport is the
// pipeline plus CSR file that feeds it and consumes its writes/redirects.
interface trap_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
);
   logic              inst_valid_i;
   logic [XLEN-1:0]   inst_addr_i;
   logic              ecall_i;
   logic              ebreak_i;
   logic              mret_i;
   logic              irq_i;
   logic [XLEN-1:0]   mtvec_i;
   logic [XLEN-1:0]   mepc_i;
   logic [XLEN-1:0]   mstatus_i;
   logic              excp_we_o;
   logic [CSR_AW-1:0] excp_waddr_o;
   logic [XLEN-1:0]   excp_wdata_o;
   logic              hold_o;
   logic              jump_o;
   logic [XLEN-1:0]   jump_addr_o;

   modport master (
      input  inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i, irq_i,
      input  mtvec_i, mepc_i, mstatus_i,
      output excp_we_o, excp_waddr_o, excp_wdata_o, hold_o, jump_o, jump_addr_o
   );

   modport slave (
      output inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i, irq_i,
      output mtvec_i, mepc_i, mstatus_i,
      input  excp_we_o, excp_waddr_o, excp_wdata_o, hold_o, jump_o, jump_addr_o
   );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Takes ecall/ebreak/mret and a gated timer
// interrupt from the execute stage, writes mepc/mcause/mstatus through the
// CSR file's single exception port one per cycle, then redirects the
// pipeline. The pipeline is held for the whole sequence.
module trap_ctrl #(
   parameter int              XLEN      = 32,
   parameter int              CSR_AW    = 12,
   parameter logic [XLEN-1:0] IRQ_CAUSE = 32'h8000_0007
) (
   input logic         clk,
   input logic         rst,
   trap_ctrl_if.master bus
);

   localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
   localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
   localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      W_MEPC   = 3'd1,
      W_MCAUSE = 3'd2,
      W_MSTAT  = 3'd3,
      T_JUMP   = 3'd4,
      R_MSTAT  = 3'd5,
      R_JUMP   = 3'd6
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   epc;
   logic [XLEN-1:0]   cause;
   logic [XLEN-1:0]   ms;

   logic              we_r;
   logic [CSR_AW-1:0] waddr_r;
   logic [XLEN-1:0]   wdata_r;
   logic              jump_r;
   logic [XLEN-1:0]   jaddr_r;

   logic              irq_ok;
   logic              accept;
   logic              take_mret;
   logic              unused_mtvec_lsb;

   // Trap entry: MPIE takes the old MIE, MIE is cleared.
   function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
      logic [XLEN-1:0] r;
      r    = m;
      r[7] = m[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // Trap return: MIE restored from MPIE, MPIE set.
   function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
      logic [XLEN-1:0] r;
      r    = m;
      r[3] = m[7];
      r[7] = 1'b1;
      return r;
   endfunction

   // Only direct-mode vectoring is supported, so the mode bits are dropped.
   assign unused_mtvec_lsb = ^bus.mtvec_i[1:0];

   assign irq_ok    = bus.irq_i && bus.mstatus_i[3];
   assign accept    = !rst && (state == IDLE) && bus.inst_valid_i &&
                      (bus.ecall_i || bus.ebreak_i || bus.mret_i || irq_ok);
   assign take_mret = !bus.ecall_i && !bus.ebreak_i && bus.mret_i;

   // Stall covers the accept cycle combinationally, then every sequence state.
   assign bus.hold_o = !rst && ((state != IDLE) || accept);

   assign bus.excp_we_o    = we_r;
   assign bus.excp_waddr_o = waddr_r;
   assign bus.excp_wdata_o = wdata_r;
   assign bus.jump_o       = jump_r;
   assign bus.jump_addr_o  = jaddr_r;

   // Sequencer: state, latched trap context and the registered Moore outputs
   // for the state being entered. mtvec/mepc are sampled one cycle before the
   // jump; the pipeline is held and this sequence never writes them, so they
   // are stable across the redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         epc     <= '0;
         cause   <= '0;
         ms      <= '0;
         we_r    <= 1'b0;
         waddr_r <= '0;
         wdata_r <= '0;
         jump_r  <= 1'b0;
         jaddr_r <= '0;
      end else begin
         we_r    <= 1'b0;
         waddr_r <= '0;
         wdata_r <= '0;
         jump_r  <= 1'b0;
         jaddr_r <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  epc <= bus.inst_addr_i;
                  ms  <= bus.mstatus_i;
                  if (bus.ecall_i)       cause <= XLEN'(11);
                  else if (bus.ebreak_i) cause <= XLEN'(3);
                  else if (bus.mret_i)   cause <= '0;
                  else                   cause <= IRQ_CAUSE;
                  we_r <= 1'b1;
                  if (take_mret) begin
                     state   <= R_MSTAT;
                     waddr_r <= ADDR_MSTATUS;
                     wdata_r <= mret_mstatus(bus.mstatus_i);
                  end else begin
                     state   <= W_MEPC;
                     waddr_r <= ADDR_MEPC;
                     wdata_r <= bus.inst_addr_i;
                  end
               end
            end
            W_MEPC: begin
               state   <= W_MCAUSE;
               we_r    <= 1'b1;
               waddr_r <= ADDR_MCAUSE;
               wdata_r <= cause;
            end
            W_MCAUSE: begin
               state   <= W_MSTAT;
               we_r    <= 1'b1;
               waddr_r <= ADDR_MSTATUS;
               wdata_r <= trap_mstatus(ms);
            end
            W_MSTAT: begin
               state   <= T_JUMP;
               jump_r  <= 1'b1;
               jaddr_r <= {bus.mtvec_i[XLEN-1:2], 2'b00};
            end
            T_JUMP: begin
               state <= IDLE;
            end
            R_MSTAT: begin
               state   <= R_JUMP;
               jump_r  <= 1'b1;
               jaddr_r <= bus.mepc_i;
            end
            R_JUMP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
